// File: rtl/led_frame_sequencer_pkg.sv
// Shared definitions for the LED frame sequencer.
//   state_t      : sequencer FSM states
//   START_BYTE   : start-frame byte value
//   END_BYTE     : end-frame byte value
//   LED_HDR      : top three bits of every per-LED header byte
//   end_bytes()  : number of 0xFF end-frame bytes needed for a strip length
package led_frame_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_FETCH,
    ST_PIXEL,
    ST_END
  } state_t;

  localparam logic [7:0] START_BYTE = 8'h00;
  localparam logic [7:0] END_BYTE   = 8'hFF;
  localparam logic [2:0] LED_HDR    = 3'b111;

  // The end frame has to supply one extra clock edge per two LEDs so the
  // data propagates to the far end of the strip; four bytes is the floor.
  function automatic int end_bytes(input int num_leds);
    int n;
    n = (num_leds + 15) / 16;
    return (n > 4) ? n : 4;
  endfunction

endpackage

// File: rtl/led_frame_sequencer_if.sv
// Byte/pixel bus between the frame sequencer, pixel RAM and SPI byte shifter.
//   pix_addr : pixel RAM read address (sequencer -> RAM)
//   pix_data : {R,G,B} read data, valid one cycle after pix_addr (RAM -> sequencer)
//   tx_data  : byte offered to the shifter (sequencer -> shifter)
//   tx_valid : tx_data valid (sequencer -> shifter)
//   tx_ready : shifter accepts the byte (shifter -> sequencer)
// master = sequencer side, slave = RAM/shifter side.
interface led_frame_sequencer_if #(
  parameter int ADDR_W = 6
) ();

  logic [ADDR_W-1:0] pix_addr;
  logic [23:0]       pix_data;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    output pix_addr,
    output tx_data,
    output tx_valid,
    input  pix_data,
    input  tx_ready
  );

  modport slave (
    input  pix_addr,
    input  tx_data,
    input  tx_valid,
    output pix_data,
    output tx_ready
  );

endinterface

// File: rtl/led_frame_sequencer.sv
// Sequences one APA102-style strip refresh: a start frame of four 0x00 bytes,
// one {hdr|brightness, B, G, R} frame per LED read from pixel RAM, then an
// end frame of 0xFF bytes. Bytes go to the SPI shifter over valid/ready.
// Ports:
//   CLK          : system clock, rising edge
//   myreset      : synchronous reset, active low
//   frame_start  : one-cycle refresh request
//   brightness   : global 5-bit brightness, captured when a frame is accepted
//   bus          : pixel RAM read port and byte handshake (master side)
//   busy         : high from frame accept until frame_done
//   frame_done   : one-cycle pulse after the last end byte is accepted
module led_frame_sequencer
  import led_frame_sequencer_pkg::*;
#(
  parameter int NUM_LEDS       = 60,
  parameter int ADDR_W         = 6,
  parameter int REFRESH_CYCLES = 0
) (
  input  logic                  CLK,
  input  logic                  myreset,
  input  logic                  frame_start,
  input  logic [4:0]            brightness,
  led_frame_sequencer_if.master bus,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int END_BYTES = end_bytes(NUM_LEDS);
  localparam int END_CNT_W = $clog2(END_BYTES + 1);
  localparam int CNT_W     = (END_CNT_W > 3) ? END_CNT_W : 3;
  localparam int REF_W     = (REFRESH_CYCLES > 0) ? $clog2(REFRESH_CYCLES + 1) : 1;

  localparam logic [ADDR_W-1:0] LAST_LED = ADDR_W'(NUM_LEDS - 1);
  localparam logic [CNT_W-1:0]  LAST_END = CNT_W'(END_BYTES - 1);
  localparam logic [CNT_W-1:0]  LAST_QUAD = CNT_W'(3);
  localparam logic [REF_W-1:0]  REF_LOAD = REF_W'(REFRESH_CYCLES);
  localparam bit                REF_EN   = (REFRESH_CYCLES > 0);

  state_t            state;
  logic [4:0]        bright;
  logic [CNT_W-1:0]  byte_cnt;
  logic [ADDR_W-1:0] led_idx;
  logic [ADDR_W-1:0] pix_addr_q;
  logic [23:0]       pix;
  logic              fetch_wait;
  logic              pending;
  logic              refresh_arm;
  logic [REF_W-1:0]  refresh_cnt;
  logic [7:0]        tx_data_q;
  logic              tx_valid_q;
  logic              busy_q;
  logic              frame_done_q;
  logic              xfer;
  logic              refresh_due;

  assign xfer        = tx_valid_q && bus.tx_ready;
  // The refresh timer only counts after a frame has completed, so a design
  // with auto-refresh still sits idle out of reset until the first request.
  assign refresh_due = refresh_arm && (refresh_cnt == '0);

  assign bus.pix_addr = pix_addr_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;
  assign busy         = busy_q;
  assign frame_done   = frame_done_q;

  // Whole frame walk. Every output is registered; tx_data only changes on a
  // transfer edge, so it stays stable while the shifter stalls.
  always_ff @(posedge CLK) begin
    if (!myreset) begin
      state        <= ST_IDLE;
      bright       <= '0;
      byte_cnt     <= '0;
      led_idx      <= '0;
      pix_addr_q   <= '0;
      pix          <= '0;
      fetch_wait   <= 1'b0;
      pending      <= 1'b0;
      refresh_arm  <= 1'b0;
      refresh_cnt  <= '0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (frame_start && (state != ST_IDLE)) begin
        pending <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (frame_start || pending || refresh_due) begin
            state       <= ST_START;
            bright      <= brightness;
            busy_q      <= 1'b1;
            byte_cnt    <= '0;
            led_idx     <= '0;
            pending     <= 1'b0;
            refresh_arm <= 1'b0;
            tx_valid_q  <= 1'b1;
            tx_data_q   <= START_BYTE;
          end else if (refresh_arm && (refresh_cnt != '0)) begin
            refresh_cnt <= refresh_cnt - REF_W'(1);
          end
        end

        ST_START: begin
          if (xfer) begin
            if (byte_cnt == LAST_QUAD) begin
              state      <= ST_FETCH;
              tx_valid_q <= 1'b0;
              byte_cnt   <= '0;
              pix_addr_q <= led_idx;
              fetch_wait <= 1'b0;
            end else begin
              byte_cnt <= byte_cnt + CNT_W'(1);
            end
          end
        end

        // First cycle presents the address to the RAM, second cycle
        // captures its registered read data.
        ST_FETCH: begin
          if (!fetch_wait) begin
            fetch_wait <= 1'b1;
          end else begin
            fetch_wait <= 1'b0;
            pix        <= bus.pix_data;
            state      <= ST_PIXEL;
            tx_valid_q <= 1'b1;
            tx_data_q  <= {LED_HDR, bright};
          end
        end

        ST_PIXEL: begin
          if (xfer) begin
            byte_cnt <= byte_cnt + CNT_W'(1);
            case (byte_cnt[1:0])
              2'd0: tx_data_q <= pix[7:0];
              2'd1: tx_data_q <= pix[15:8];
              2'd2: tx_data_q <= pix[23:16];
              default: begin
                byte_cnt <= '0;
                if (led_idx == LAST_LED) begin
                  state     <= ST_END;
                  tx_data_q <= END_BYTE;
                end else begin
                  state      <= ST_FETCH;
                  tx_valid_q <= 1'b0;
                  led_idx    <= led_idx + ADDR_W'(1);
                  pix_addr_q <= led_idx + ADDR_W'(1);
                  fetch_wait <= 1'b0;
                end
              end
            endcase
          end
        end

        ST_END: begin
          if (xfer) begin
            if (byte_cnt == LAST_END) begin
              state        <= ST_IDLE;
              tx_valid_q   <= 1'b0;
              busy_q       <= 1'b0;
              frame_done_q <= 1'b1;
              byte_cnt     <= '0;
              refresh_cnt  <= REF_LOAD;
              refresh_arm  <= REF_EN;
            end else begin
              byte_cnt <= byte_cnt + CNT_W'(1);
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_frame_sequencer.sv
// Self-checking bench for led_frame_sequencer.
// Two instances: dut (no auto-refresh) and dut_r (REFRESH_CYCLES=10), both
// with a 3-LED strip and a 1-cycle-latency pixel RAM model. Expected bytes
// are pushed to per-instance queues when a frame is requested and popped
// by monitors on every accepted byte.
module tb_led_frame_sequencer;
  import led_frame_sequencer_pkg::*;

  localparam int NL = 3;
  localparam int AW = 2;
  localparam int EB = 4;

  logic       CLK = 1'b0;
  logic       myreset, myreset_r;
  logic       frame_start, frame_start_r;
  logic [4:0] brightness, brightness_r;
  logic       busy, frame_done, busy_r, frame_done_r;

  led_frame_sequencer_if #(.ADDR_W(AW)) bus ();
  led_frame_sequencer_if #(.ADDR_W(AW)) bus_r ();

  led_frame_sequencer #(.NUM_LEDS(NL), .ADDR_W(AW), .REFRESH_CYCLES(0)) dut (
    .CLK(CLK), .myreset(myreset), .frame_start(frame_start), .brightness(brightness),
    .bus(bus.master), .busy(busy), .frame_done(frame_done)
  );

  led_frame_sequencer #(.NUM_LEDS(NL), .ADDR_W(AW), .REFRESH_CYCLES(10)) dut_r (
    .CLK(CLK), .myreset(myreset_r), .frame_start(frame_start_r), .brightness(brightness_r),
    .bus(bus_r.master), .busy(busy_r), .frame_done(frame_done_r)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [4:0]  bright;
    logic [23:0] px0;
    logic [23:0] px1;
    logic [23:0] px2;
    int          ready_pct;
    logic [7:0]  hdr;
    int          xfers;
  } vec_t;

  vec_t        vecs[4];
  logic [23:0] ram[4];
  logic [7:0]  q_a[$];
  logic [7:0]  q_r[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ready_pct = 100;
  int xfer_a = 0, xfer_r = 0;
  int done_a = 0, done_r = 0;
  int done_cyc_a = 0, done_cyc_r = 0;
  int gap_a = -1, gap_r = -1;
  bit want_a = 0, want_r = 0;
  bit stall_a = 0, stall_r = 0;
  logic [7:0] held_a, held_r;

  // Pixel RAM model with registered read data.
  always @(posedge CLK) begin
    bus.pix_data   <= ram[bus.pix_addr];
    bus_r.pix_data <= ram[bus_r.pix_addr];
  end

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  // Shifter ready for dut: random with the current acceptance percentage.
  initial begin
    bus.tx_ready   = 1'b1;
    bus_r.tx_ready = 1'b1;
    forever begin
      @(posedge CLK);
      #1;
      bus.tx_ready = (int'($urandom_range(99)) < ready_pct);
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor for dut: scoreboard pop on transfer, stall stability, frame_done.
  initial forever begin
    @(negedge CLK);
    if (myreset) begin
      if (stall_a) begin
        checkOutput("a_stall_valid", 32'(bus.tx_valid), 32'd1);
        checkOutput("a_stall_data", 32'(bus.tx_data), 32'(held_a));
      end
      if (bus.tx_valid && bus.tx_ready) begin
        xfer_a++;
        if (q_a.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL a_extra_byte: got %0h expected no byte", bus.tx_data);
        end else begin
          checkOutput("a_tx_byte", 32'(bus.tx_data), 32'(q_a.pop_front()));
        end
      end
      stall_a = bus.tx_valid && !bus.tx_ready;
      held_a  = bus.tx_data;
      if (frame_done) begin
        done_a++;
        done_cyc_a = cyc;
        want_a = 1;
      end else if (want_a && bus.tx_valid) begin
        if (gap_a < 0) gap_a = cyc - done_cyc_a;
        want_a = 0;
      end
    end else begin
      stall_a = 0;
    end
  end

  // Monitor for dut_r, same scheme.
  initial forever begin
    @(negedge CLK);
    if (myreset_r) begin
      if (bus_r.tx_valid && bus_r.tx_ready) begin
        xfer_r++;
        if (q_r.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL r_extra_byte: got %0h expected no byte", bus_r.tx_data);
        end else begin
          checkOutput("r_tx_byte", 32'(bus_r.tx_data), 32'(q_r.pop_front()));
        end
      end
      if (frame_done_r) begin
        done_r++;
        done_cyc_r = cyc;
        want_r = 1;
      end else if (want_r && bus_r.tx_valid) begin
        if (gap_r < 0) gap_r = cyc - done_cyc_r;
        want_r = 0;
      end
    end
  end

  // Reference byte stream for one frame from the current RAM contents.
  task automatic pushFrame(input bit on_r, input logic [7:0] hdr);
    logic [7:0] b[$];
    for (int i = 0; i < 4; i++) b.push_back(8'h00);
    for (int i = 0; i < NL; i++) begin
      b.push_back(hdr);
      b.push_back(ram[i][7:0]);
      b.push_back(ram[i][15:8]);
      b.push_back(ram[i][23:16]);
    end
    for (int i = 0; i < EB; i++) b.push_back(8'hFF);
    foreach (b[i]) begin
      if (on_r) q_r.push_back(b[i]);
      else q_a.push_back(b[i]);
    end
  endtask

  task automatic applyStimulus(input bit on_r);
    @(posedge CLK);
    #1;
    if (on_r) frame_start_r = 1'b1;
    else frame_start = 1'b1;
    @(posedge CLK);
    #1;
    frame_start   = 1'b0;
    frame_start_r = 1'b0;
  endtask

  task automatic waitDone(input bit on_r, input int target, input int budget);
    int n = 0;
    while (((on_r ? done_r : done_a) < target) && (n < budget)) begin
      @(posedge CLK);
      #1;
      n++;
    end
    if ((on_r ? done_r : done_a) < target) begin
      checks++;
      errors++;
      $display("[TB] FAIL frame_done_timeout: saw %0d pulses need %0d",
               on_r ? done_r : done_a, target);
    end
  endtask

  initial begin
    vecs[0] = '{5'h1F, 24'h112233, 24'h445566, 24'h778899, 100, 8'hFF, 20};
    vecs[1] = '{5'h1F, 24'h112233, 24'h445566, 24'h778899, 50,  8'hFF, 20};
    vecs[2] = '{5'h03, 24'hAABBCC, 24'h000000, 24'hFFFFFF, 100, 8'hE3, 20};
    vecs[3] = '{5'h0A, 24'h010203, 24'h040506, 24'h070809, 30,  8'hEA, 20};

    myreset       = 1'b0;
    myreset_r     = 1'b0;
    frame_start   = 1'b0;
    frame_start_r = 1'b0;
    brightness    = 5'h00;
    brightness_r  = 5'h00;
    ram[0] = 24'h112233; ram[1] = 24'h445566; ram[2] = 24'h778899; ram[3] = 24'h0;

    // Reset held four cycles, then released.
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK);
      #1;
      checkOutput("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_pix_addr", 32'(bus.pix_addr), 32'd0);
      checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
    end
    myreset   = 1'b1;
    myreset_r = 1'b1;
    @(posedge CLK);
    #1;
    checkOutput("post_rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    checkOutput("post_rst_busy", 32'(busy), 32'd0);
    checkOutput("post_rst_pix_addr", 32'(bus.pix_addr), 32'd0);

    // Auto-refresh instance must not start on its own before any frame.
    repeat (20) @(posedge CLK);
    #1;
    checkOutput("r_idle_xfers", 32'(xfer_r), 32'd0);
    checkOutput("r_idle_busy", 32'(busy_r), 32'd0);

    // Table-driven single frames.
    for (int v = 0; v < 4; v++) begin
      ram[0] = vecs[v].px0; ram[1] = vecs[v].px1; ram[2] = vecs[v].px2;
      ready_pct  = vecs[v].ready_pct;
      brightness = vecs[v].bright;
      xfer_a = 0;
      done_a = 0;
      pushFrame(0, vecs[v].hdr);
      applyStimulus(0);
      checkOutput("vec_busy", 32'(busy), 32'd1);
      waitDone(0, 1, 2000);
      repeat (5) @(posedge CLK);
      #1;
      checkOutput("vec_xfers", 32'(xfer_a), 32'(vecs[v].xfers));
      checkOutput("vec_done_pulses", 32'(done_a), 32'd1);
      checkOutput("vec_queue_left", 32'(q_a.size()), 32'd0);
      checkOutput("vec_busy_after", 32'(busy), 32'd0);
    end
    ready_pct = 100;

    // Two extra requests during a frame: one is queued, the other dropped.
    ram[0] = 24'h112233; ram[1] = 24'h445566; ram[2] = 24'h778899;
    brightness = 5'h1F;
    xfer_a = 0; done_a = 0; gap_a = -1; want_a = 0;
    pushFrame(0, 8'hFF);
    pushFrame(0, 8'hFF);
    applyStimulus(0);
    repeat (4) @(posedge CLK);
    applyStimulus(0);
    repeat (4) @(posedge CLK);
    applyStimulus(0);
    waitDone(0, 2, 4000);
    repeat (50) @(posedge CLK);
    #1;
    checkOutput("pend_done_pulses", 32'(done_a), 32'd2);
    checkOutput("pend_xfers", 32'(xfer_a), 32'd40);
    checkOutput("pend_restart_gap", 32'(gap_a), 32'd1);
    checkOutput("pend_queue_left", 32'(q_a.size()), 32'd0);
    checkOutput("pend_busy_after", 32'(busy), 32'd0);

    // Reset while the G byte of the first LED is offered.
    xfer_a = 0; done_a = 0;
    pushFrame(0, 8'hFF);
    applyStimulus(0);
    for (int n = 0; (n < 200) && (xfer_a < 6); n++) begin
      @(posedge CLK);
      #1;
    end
    checkOutput("midrst_reached", 32'(xfer_a), 32'd6);
    myreset = 1'b0;
    @(posedge CLK);
    #1;
    checkOutput("midrst_tx_valid", 32'(bus.tx_valid), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_pix_addr", 32'(bus.pix_addr), 32'd0);
    myreset = 1'b1;
    q_a.delete();
    xfer_a = 0; done_a = 0;
    pushFrame(0, 8'hFF);
    applyStimulus(0);
    waitDone(0, 1, 2000);
    repeat (5) @(posedge CLK);
    #1;
    checkOutput("midrst_clean_xfers", 32'(xfer_r * 0 + xfer_a), 32'd20);
    checkOutput("midrst_queue_left", 32'(q_a.size()), 32'd0);

    // Auto-refresh: restart 11 cycles after frame_done, new brightness
    // only from the second frame.
    brightness_r = 5'h1F;
    xfer_r = 0; done_r = 0; gap_r = -1; want_r = 0;
    pushFrame(1, 8'hFF);
    pushFrame(1, 8'hE3);
    applyStimulus(1);
    for (int n = 0; (n < 200) && (xfer_r < 8); n++) begin
      @(posedge CLK);
      #1;
    end
    brightness_r = 5'h03;
    waitDone(1, 2, 4000);
    myreset_r = 1'b0;
    @(posedge CLK);
    #1;
    checkOutput("ref_gap", 32'(gap_r), 32'd11);
    checkOutput("ref_done_pulses", 32'(done_r), 32'd2);
    checkOutput("ref_xfers", 32'(xfer_r), 32'd40);
    checkOutput("ref_queue_left", 32'(q_r.size()), 32'd0);
    checkOutput("ref_rst_busy", 32'(busy_r), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
